// File: rtl/hero_dir_ctrl.sv
// hero_dir_ctrl
//   Turns raw player push-buttons into a registered direction code for the
//   sprite movement/render logic. Each button bit passes through a two-flop
//   synchroniser and a per-bit debounce filter. The debounced vector is then
//   decoded into a candidate direction, using the multi-press policy set by
//   MULTI_MODE. A change of direction updates state/old_state, pulses
//   changed/step, and pushes the previous direction into a short history.
//   While a direction is held, step can auto-repeat every REPEAT_CYCLES
//   cycles.
//
// Ports
//   clk         game clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn         raw asynchronous buttons, active high, bit i = direction i
//   enable      low freezes state/history/strobes (debounce keeps running)
//   state       current direction code
//   old_state   direction held before the last change
//   changed     one-cycle pulse when state changes
//   step        one-cycle move request (on change and on auto-repeat)
//   hist        past directions, slot 0 (LSBs) = most recent prior direction
//   hist_count  number of valid history slots, saturates at HIST_DEPTH

module hero_dir_ctrl #(
    parameter int NUM_DIRS        = 4,
    parameter int DIR_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0,
    parameter int HIST_DEPTH      = 4,
    parameter int MULTI_MODE      = 0,
    parameter int RESET_DIR       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIRS-1:0]           btn,
    input  logic                          enable,
    output logic [DIR_W-1:0]              state,
    output logic [DIR_W-1:0]              old_state,
    output logic                          changed,
    output logic                          step,
    output logic [HIST_DEPTH*DIR_W-1:0]   hist,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

    localparam int HC_W     = $clog2(HIST_DEPTH + 1);
    localparam int HIST_W   = HIST_DEPTH * DIR_W;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int RPT_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    localparam logic [DIR_W-1:0] RST_CODE  = DIR_W'(RESET_DIR);
    localparam logic [DB_W-1:0]  DB_TERM   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] RPT_TERM  = RPT_W'(RPT_LAST);
    localparam logic [HC_W-1:0]  HC_FULL   = HC_W'(HIST_DEPTH);

    logic [NUM_DIRS-1:0] sync_a;
    logic [NUM_DIRS-1:0] sync_b;
    logic [NUM_DIRS-1:0] db;
    logic [DB_W-1:0]     db_cnt [NUM_DIRS];

    logic [DIR_W-1:0]    low_idx;
    logic                multi;
    logic                cand_valid;
    logic [HIST_W-1:0]   hist_next;
    logic [RPT_W-1:0]    rpt_cnt;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Per-bit debounce: db flips only on the edge where the counter has
    // already seen DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < NUM_DIRS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (sync_b[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TERM) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Candidate decode. Descending scan leaves the lowest set index;
    // db & (db-1) is non-zero exactly when two or more bits are set.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (db[i]) begin
                low_idx = DIR_W'(i);
            end
        end
        multi      = |(db & (db - NUM_DIRS'(1)));
        cand_valid = (|db) && (!multi || (MULTI_MODE == 1));
    end

    always_comb begin
        hist_next                = hist << DIR_W;
        hist_next[DIR_W-1:0]     = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_CODE;
            old_state  <= RST_CODE;
            hist       <= {HIST_DEPTH{RST_CODE}};
            hist_count <= '0;
            changed    <= 1'b0;
            step       <= 1'b0;
            rpt_cnt    <= '0;
        end else if (!enable) begin
            changed <= 1'b0;
            step    <= 1'b0;
            rpt_cnt <= '0;
        end else if (cand_valid && (low_idx != state)) begin
            state     <= low_idx;
            old_state <= state;
            hist      <= hist_next;
            if (hist_count != HC_FULL) begin
                hist_count <= hist_count + HC_W'(1);
            end
            changed <= 1'b1;
            step    <= 1'b1;
            rpt_cnt <= '0;
        end else if (cand_valid && (REPEAT_CYCLES > 0)) begin
            // Held direction: count out the auto-repeat period.
            changed <= 1'b0;
            if (rpt_cnt == RPT_TERM) begin
                step    <= 1'b1;
                rpt_cnt <= '0;
            end else begin
                step    <= 1'b0;
                rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
        end else begin
            changed <= 1'b0;
            step    <= 1'b0;
            rpt_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hero_dir_ctrl.sv
module tb_hero_dir_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       enable;

    logic [1:0] state0, old0, state1, old1;
    logic       ch0, st0, ch1, st1;
    logic [7:0] hist0, hist1;
    logic [2:0] hc0, hc1;

    int compared = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    // dut0: ignore multi-press, no repeat. dut1: lowest index wins, repeat 5.
    hero_dir_ctrl #(.NUM_DIRS(4), .DIR_W(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0),
                    .HIST_DEPTH(4), .MULTI_MODE(0), .RESET_DIR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable),
        .state(state0), .old_state(old0), .changed(ch0), .step(st0),
        .hist(hist0), .hist_count(hc0));

    hero_dir_ctrl #(.NUM_DIRS(4), .DIR_W(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(5),
                    .HIST_DEPTH(4), .MULTI_MODE(1), .RESET_DIR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable),
        .state(state1), .old_state(old1), .changed(ch1), .step(st1),
        .hist(hist1), .hist_count(hc1));

    // ---------------- reference model ----------------
    localparam int D = 4;
    localparam int R = 5;

    typedef struct {
        bit ch;
        bit st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [3:0] m_p1, m_p2, m_db;
    int m_run[4];
    int m_state[2], m_old[2], m_hc[2], m_held[2];
    int m_hist[2][4];

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int pack_hist(input int c);
        int v = 0;
        for (int k = 0; k < 4; k++) v = v | (m_hist[c][k] << (2 * k));
        return v;
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_db = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        for (int c = 0; c < 2; c++) begin
            m_state[c] = 0; m_old[c] = 0; m_hc[c] = 0; m_held[c] = 0;
            for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge(input logic [3:0] b, input logic en);
        int   n, cidx;
        bit   valid;
        exp_t e;
        n    = $countones(m_db);
        cidx = 0;
        for (int i = 3; i >= 0; i--) if (m_db[i]) cidx = i;
        for (int c = 0; c < 2; c++) begin
            valid = (n == 1) || (n > 1 && c == 1);
            e.ch = 0;
            e.st = 0;
            if (!en) begin
                m_held[c] = 0;
            end else if (valid && cidx != m_state[c]) begin
                for (int k = 3; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = m_state[c];
                if (m_hc[c] < 4) m_hc[c]++;
                m_old[c]   = m_state[c];
                m_state[c] = cidx;
                e.ch = 1;
                e.st = 1;
                m_held[c] = 0;
            end else if (valid && c == 1) begin
                m_held[c]++;
                if (m_held[c] == R) begin
                    e.st = 1;
                    m_held[c] = 0;
                end
            end else begin
                m_held[c] = 0;
            end
            if (e.ch || e.st) begin
                if (c == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        // debounce: a bit flips once the synchronised input has disagreed
        // for D full cycles before this edge
        for (int i = 0; i < 4; i++) begin
            if (m_p2[i] == m_db[i]) m_run[i] = 0;
            else if (m_run[i] == D) begin
                m_db[i]  = ~m_db[i];
                m_run[i] = 0;
            end else m_run[i]++;
        end
        m_p2 = m_p1;
        m_p1 = b;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_edge(btn, enable);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int c, input logic [1:0] s, input logic [1:0] o,
                       input logic [7:0] h, input logic [2:0] hc,
                       input logic ch, input logic st);
        exp_t e;
        int   eh;
        eh = pack_hist(c);
        compared++;
        if (s != m_state[c] || o != m_old[c] || h != eh || hc != m_hc[c]) begin
            errors++;
            $display("FAIL regs dut%0d t=%0t: got state=%0d old=%0d hist=%h cnt=%0d, want state=%0d old=%0d hist=%h cnt=%0d",
                     c, $time, s, o, h, hc, m_state[c], m_old[c], eh, m_hc[c]);
        end
        if (ch || st) begin
            compared++;
            if (qsize(c) == 0) begin
                errors++;
                $display("FAIL unexpected_pulse dut%0d t=%0t: got changed=%0d step=%0d, want none",
                         c, $time, ch, st);
            end else begin
                if (c == 0) e = q0.pop_front();
                else e = q1.pop_front();
                if (e.ch != ch || e.st != st) begin
                    errors++;
                    $display("FAIL pulse dut%0d t=%0t: got changed=%0d step=%0d, want changed=%0d step=%0d",
                             c, $time, ch, st, e.ch, e.st);
                end
            end
        end
        if (qsize(c) != 0) begin
            compared++;
            errors++;
            $display("FAIL missed_pulse dut%0d t=%0t: got changed=%0d step=%0d, want a pulse",
                     c, $time, ch, st);
            if (c == 0) q0.delete();
            else q1.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, state0, old0, hist0, hc0, ch0, st0);
            mon(1, state1, old1, hist1, hc1, ch1, st1);
        end
    end

    // ---------------- directed checks and stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses, steps, chs;
        rst_n  = 1'b0;
        btn    = '0;
        enable = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // async reset mid-run
        btn = 4'b1000;
        cyc(12);
        chk("pre_reset_state", state0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        btn = '0;
        #1;
        chk("rst_state",     state0, 0);
        chk("rst_old_state", old0, 0);
        chk("rst_hist_count", hc0, 0);
        chk("rst_changed",   ch0, 0);
        chk("rst_step",      st0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6);

        // latency: state appears 7 edges after the first sampling edge
        btn = 4'b0100;
        repeat (7) @(posedge clk);
        #1 chk("latency_early_state", state0, 0);
        @(posedge clk);
        #1;
        chk("latency_state",   state0, 2);
        chk("latency_changed", ch0, 1);
        chk("latency_step",    st0, 1);
        chk("latency_old",     old0, 0);
        chk("latency_hist0",   hist0[1:0], 0);
        chk("latency_hcount",  hc0, 1);
        @(posedge clk);
        #1 chk("changed_one_cycle", ch0, 0);
        cyc(12);

        // 3-cycle glitch never reaches state
        btn = 4'b1000;
        cyc(3);
        btn = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 if (ch0 || st0) pulses++;
        end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_state", state0, 2);

        // multi-press policy
        @(negedge clk);
        btn = 4'b0110;
        cyc(15);
        chk("multi_ignore_state", state0, 2);
        chk("multi_lowest_state", state1, 1);

        // auto-repeat: change at edge 8, steps every 5 edges after
        btn = 4'b0001;
        cyc(12);
        btn = 4'b0010;
        repeat (7) @(posedge clk);
        steps = 0;
        chs   = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (st1) steps++;
            if (ch1) chs++;
        end
        chk("repeat_steps",   steps, 6);
        chk("repeat_changed", chs, 1);

        // history sequence 0->1->2->3->0 with an enable gap
        @(negedge clk);
        rst_n = 1'b0;
        btn   = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        btn = 4'b0010; cyc(12);
        btn = 4'b0100; cyc(12);
        enable = 1'b0;
        btn = 4'b1000;
        cyc(10);
        chk("disabled_state",  state0, 2);
        chk("disabled_hcount", hc0, 2);
        enable = 1'b1;
        @(posedge clk);
        #1 chk("reenable_state", state0, 3);
        @(negedge clk);
        btn = 4'b0001;
        cyc(12);
        chk("seq_state",     state0, 0);
        chk("seq_old",       old0, 3);
        chk("seq_hist",      hist0, 8'h1B);
        chk("seq_hcount",    hc0, 4);
        chk("seq_hist_dut1", hist1, 8'h1B);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            btn    = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) != 0);
            cyc($urandom_range(1, 12));
        end
        btn    = '0;
        enable = 1'b1;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
